// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line constants shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic LINE_IDLE            = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter 0..CLKS_PER_BIT-1 with a one-cycle tick at terminal count.
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start bit + LSB-first data + stop bit(s), valid/ready word input.
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);

    uart_state_t          state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic                 txd_n, tick, last_data, last_stop;

    // Baud counter is held at zero while idle so every frame starts on a fresh bit period.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign tx_ready  = state == IDLE;
    assign busy      = ~tx_ready;
    assign last_data = bit_cnt == BW'(DATA_BITS - 1);
    assign last_stop = bit_cnt == BW'(STOP_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            txd     <= LINE_IDLE;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            txd     <= txd_n;
        end
    end

    // bit_cnt counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        txd_n   = txd;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = START;
                shift_n = tx_data;
                bit_n   = '0;
                txd_n   = 1'b0;
            end
            START: if (tick) begin
                state_n = DATA;
                txd_n   = shift[0];
            end
            DATA: if (tick) begin
                shift_n = shift >> 1;
                state_n = last_data ? STOP : DATA;
                bit_n   = last_data ? '0 : bit_cnt + 1'b1;
                txd_n   = last_data ? LINE_IDLE : shift[1];
            end
            STOP: if (tick) begin
                state_n = last_stop ? IDLE : STOP;
                bit_n   = last_stop ? '0 : bit_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
